// File: rtl/rf_proc_sequencer.sv
// Runs a packed procedure word (eight 3-bit step codes, LSB first) against the register file,
// accumulating target <= target + reg[OPR_BASE+code] until the first zero code or eight steps.
module rf_proc_sequencer #(
  parameter logic [3:0] OPR_BASE = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  proc_sel,
  input  logic [3:0]  tgt_sel,
  input  logic [23:0] rf_outa,
  input  logic [23:0] rf_outb,
  output logic [3:0]  rf_src0,
  output logic [3:0]  rf_src1,
  output logic [3:0]  rf_dst,
  output logic [23:0] rf_data,
  output logic        rf_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  steps_run
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StRead, StWrite, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_tgt, w_tgt_d;
  logic [23:0] r_step_sr, w_step_sr_d;
  logic [3:0]  r_step_cnt, w_step_cnt_d;
  logic [3:0]  r_src0, w_src0_d;
  logic [3:0]  r_src1, w_src1_d;
  logic [3:0]  r_dst, w_dst_d;
  logic [23:0] r_data, w_data_d;
  logic        r_we, w_we_d;
  logic        r_busy, w_busy_d;
  logic        r_done, w_done_d;
  logic        r_err, w_err_d;
  logic [3:0]  r_steps_run, w_steps_run_d;
  logic [2:0]  w_code;

  assign w_code = r_step_sr[2:0];

  always_comb begin
    w_state_d     = r_state;
    w_tgt_d       = r_tgt;
    w_step_sr_d   = r_step_sr;
    w_step_cnt_d  = r_step_cnt;
    w_src0_d      = r_src0;
    w_src1_d      = r_src1;
    w_dst_d       = r_dst;
    w_data_d      = r_data;
    w_we_d        = 1'b0;
    w_busy_d      = r_busy;
    w_done_d      = 1'b0;
    w_err_d       = 1'b0;
    w_steps_run_d = r_steps_run;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (tgt_sel == proc_sel) begin
            w_err_d = 1'b1;
          end else begin
            w_tgt_d   = tgt_sel;
            w_src0_d  = proc_sel;
            w_busy_d  = 1'b1;
            w_state_d = StFetch;
          end
        end
      end
      StFetch: begin
        w_step_sr_d  = rf_outa;
        w_step_cnt_d = 4'd0;
        w_state_d    = StDecode;
      end
      StDecode: begin
        if (w_code == 3'd0 || r_step_cnt == 4'd8) begin
          w_steps_run_d = r_step_cnt;
          w_done_d      = 1'b1;
          w_state_d     = StDone;
        end else begin
          w_src0_d  = r_tgt;
          w_src1_d  = OPR_BASE + {1'b0, w_code};
          w_state_d = StRead;
        end
      end
      StRead: begin
        // Operand is read before this step's commit, so operand==target simply doubles.
        w_dst_d   = r_tgt;
        w_data_d  = rf_outa + rf_outb;
        w_we_d    = 1'b1;
        w_state_d = StWrite;
      end
      StWrite: begin
        w_step_sr_d  = r_step_sr >> 3;
        w_step_cnt_d = r_step_cnt + 4'd1;
        w_state_d    = StDecode;
      end
      StDone: begin
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    if (abort && r_state != StIdle) begin
      w_we_d        = 1'b0;
      w_busy_d      = 1'b0;
      w_done_d      = 1'b0;
      w_steps_run_d = r_steps_run;
      w_state_d     = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_tgt       <= 4'd0;
      r_step_sr   <= 24'd0;
      r_step_cnt  <= 4'd0;
      r_src0      <= 4'd0;
      r_src1      <= 4'd0;
      r_dst       <= 4'd0;
      r_data      <= 24'd0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_steps_run <= 4'd0;
    end else begin
      r_state     <= w_state_d;
      r_tgt       <= w_tgt_d;
      r_step_sr   <= w_step_sr_d;
      r_step_cnt  <= w_step_cnt_d;
      r_src0      <= w_src0_d;
      r_src1      <= w_src1_d;
      r_dst       <= w_dst_d;
      r_data      <= w_data_d;
      r_we        <= w_we_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      r_steps_run <= w_steps_run_d;
    end
  end

  assign rf_src0   = r_src0;
  assign rf_src1   = r_src1;
  assign rf_dst    = r_dst;
  assign rf_data   = r_data;
  assign rf_we     = r_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign steps_run = r_steps_run;

endmodule

// File: tb/tb_rf_proc_sequencer.sv
// Directed bench for rf_proc_sequencer: two instances (OPR_BASE 8 and 12), each with its own
// behavioural 16x24 register file; expected values are hand-computed constants.
module tb_rf_proc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start_b, abort, load;
  logic [3:0] proc_sel, tgt_sel;

  logic [23:0] a_outa, a_outb, a_data, b_outa, b_outb, b_data;
  logic [3:0]  a_src0, a_src1, a_dst, a_steps, b_src0, b_src1, b_dst, b_steps;
  logic        a_we, a_busy, a_done, a_err, b_we, b_busy, b_done, b_err;

  logic [23:0] rf_a [16];
  logic [23:0] rf_b [16];
  logic [23:0] init_a [16];
  logic [23:0] init_b [16];
  logic [23:0] log_a [16];
  int wr_a, wr_b;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int at;
  int n_done;

  rf_proc_sequencer #(.OPR_BASE(4'd8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .proc_sel(proc_sel), .tgt_sel(tgt_sel), .rf_outa(a_outa), .rf_outb(a_outb),
    .rf_src0(a_src0), .rf_src1(a_src1), .rf_dst(a_dst), .rf_data(a_data), .rf_we(a_we),
    .busy(a_busy), .done(a_done), .err(a_err), .steps_run(a_steps)
  );

  rf_proc_sequencer #(.OPR_BASE(4'd12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .proc_sel(proc_sel), .tgt_sel(tgt_sel), .rf_outa(b_outa), .rf_outb(b_outb),
    .rf_src0(b_src0), .rf_src1(b_src1), .rf_dst(b_dst), .rf_data(b_data), .rf_we(b_we),
    .busy(b_busy), .done(b_done), .err(b_err), .steps_run(b_steps)
  );

  assign a_outa = rf_a[a_src0];
  assign a_outb = rf_a[a_src1];
  assign b_outa = rf_b[b_src0];
  assign b_outb = rf_b[b_src1];

  always @(posedge clk) begin
    if (load) begin
      rf_a <= init_a;
      rf_b <= init_b;
      wr_a <= 0;
      wr_b <= 0;
    end else begin
      if (a_we) begin
        rf_a[a_dst]       <= a_data;
        log_a[wr_a[3:0]]  <= a_data;
        wr_a              <= wr_a + 1;
      end
      if (b_we) begin
        rf_b[b_dst] <= b_data;
        wr_b        <= wr_b + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_rf();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic std_init();
    init_a = '{default: 24'd0};
    init_a[7]  = 24'h1F58D1;  // codes 1..7 then 0
    init_a[9]  = 24'h200000;
    init_a[12] = 24'd1;
    init_a[14] = 24'd1;
    init_a[15] = 24'd2;
    init_b = '{default: 24'd0};
  endtask

  // The cycle holding the start-sampling edge's result is cycle 1.
  task automatic go(input bit sel, input logic [3:0] p, input logic [3:0] t);
    proc_sel = p;
    tgt_sel  = t;
    if (sel) start_b = 1'b1;
    else start = 1'b1;
    tick();
    start   = 1'b0;
    start_b = 1'b0;
    cyc     = 1;
  endtask

  task automatic wait_done(input bit sel, output int when);
    when = -1;
    for (int i = 0; i < 60; i++) begin
      if (sel ? b_done : a_done) begin
        when = cyc;
        break;
      end
      tick();
    end
  endtask

  logic [23:0] exp7 [7];

  initial begin
    exp7 = '{24'h200000, 24'h200000, 24'h200000, 24'h200001, 24'h400002, 24'h400003,
             24'h400005};
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; abort = 1'b0; load = 1'b0;
    proc_sel = 4'd0; tgt_sel = 4'd0;
    std_init();
    load_rf();
    tick();
    tick();
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_done", a_done, 0);
    check_eq("rst_err", a_err, 0);
    check_eq("rst_we", a_we, 0);
    check_eq("rst_steps", a_steps, 0);
    check_eq("rst_addr", {a_src0, a_src1, a_dst}, 0);
    check_eq("rst_data", a_data, 0);
    rst_n = 1'b1;
    tick();

    // Empty procedure: zero steps.
    go(1'b0, 4'd6, 4'd0);
    check_eq("t0_busy_c1", a_busy, 1);
    wait_done(1'b0, at);
    check_eq("t0_done_cyc", at, 3);
    check_eq("t0_steps", a_steps, 0);
    tick();
    check_eq("t0_writes", wr_a, 0);
    check_eq("t0_reg0", rf_a[0], 0);

    // Rejected start: target equals procedure register.
    go(1'b0, 4'd7, 4'd7);
    check_eq("err_pulse", a_err, 1);
    check_eq("err_busy", a_busy, 0);
    tick();
    check_eq("err_clear", a_err, 0);
    check_eq("err_busy2", a_busy, 0);
    check_eq("err_writes", wr_a, 0);

    // Seven steps with a start pulse mid-run that must be ignored.
    go(1'b0, 4'd7, 4'd13);
    while (cyc < 5) tick();
    proc_sel = 4'd6;
    tgt_sel  = 4'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, at);
    check_eq("t7_done_cyc", at, 24);
    check_eq("t7_steps", a_steps, 7);
    tick();
    check_eq("t7_busy_off", a_busy, 0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_done) n_done++;
      tick();
    end
    check_eq("t7_extra_done", n_done, 0);
    check_eq("t7_writes", wr_a, 7);
    for (int i = 0; i < 7; i++) check_eq($sformatf("t7_wr%0d", i), log_a[i], exp7[i]);
    check_eq("t7_reg13", rf_a[13], 24'h400005);

    // Eight code-1 steps.
    init_a = '{default: 24'd0};
    init_a[2] = 24'h249249;
    init_a[9] = 24'd1;
    load_rf();
    go(1'b0, 4'd2, 4'd0);
    wait_done(1'b0, at);
    check_eq("t8_done_cyc", at, 27);
    check_eq("t8_steps", a_steps, 8);
    tick();
    check_eq("t8_reg0", rf_a[0], 8);
    check_eq("t8_writes", wr_a, 8);

    // Abort in the READ cycle of step 3.
    std_init();
    load_rf();
    go(1'b0, 4'd7, 4'd13);
    while (cyc < 9) tick();
    check_eq("ab_read_src1", a_src1, 4'd11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_busy", a_busy, 0);
    check_eq("ab_we", a_we, 0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_done) n_done++;
      tick();
    end
    check_eq("ab_no_done", n_done, 0);
    check_eq("ab_writes", wr_a, 2);
    check_eq("ab_reg13", rf_a[13], 24'h200000);
    check_eq("ab_steps", a_steps, 8);

    // OPR_BASE=12: code 7 wraps to operand index 3.
    std_init();
    init_b[1] = 24'h000010;
    init_b[3] = 24'h000005;
    init_b[5] = 24'h000007;
    load_rf();
    go(1'b1, 4'd5, 4'd1);
    wait_done(1'b1, at);
    check_eq("wrap_done_cyc", at, 6);
    check_eq("wrap_steps", b_steps, 1);
    tick();
    check_eq("wrap_reg1", rf_b[1], 24'h000015);
    check_eq("wrap_writes", wr_b, 1);

    // Reset asserted during the WRITE cycle of step 1.
    std_init();
    load_rf();
    go(1'b0, 4'd7, 4'd13);
    while (cyc < 4) tick();
    check_eq("rw_we_in_write", a_we, 1);
    rst_n = 1'b0;
    tick();
    check_eq("rw_we", a_we, 0);
    check_eq("rw_busy", a_busy, 0);
    check_eq("rw_data", a_data, 0);
    check_eq("rw_addr", {a_src0, a_src1, a_dst}, 0);
    check_eq("rw_steps", a_steps, 0);
    check_eq("rw_reg13", rf_a[13], 24'h200000);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check_eq("rw_writes", wr_a, 1);
    check_eq("rw_busy_after", a_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
